// File: rtl/gshare_bht_multi_if.sv
// Fetch-side bundle for the gshare BHT: lookup address, resolution update and per-slot predictions.
interface gshare_bht_multi_if #(
   parameter int unsigned VLEN            = 32,
   parameter int unsigned INSTR_PER_FETCH = 2
);
   logic [VLEN-1:0]            vpc;
   logic                       upd_valid;
   logic [VLEN-1:0]            upd_pc;
   logic                       upd_taken;
   logic [INSTR_PER_FETCH-1:0] pred_valid;
   logic [INSTR_PER_FETCH-1:0] pred_taken;

   modport master (
      output vpc, upd_valid, upd_pc, upd_taken,
      input  pred_valid, pred_taken
   );

   modport slave (
      input  vpc, upd_valid, upd_pc, upd_taken,
      output pred_valid, pred_taken
   );
endinterface

// File: rtl/gshare_bht_multi.sv
// Gshare BHT with INSTR_PER_FETCH predictions per fetch and a row-sweep clear FSM.
// Optional performance counters are enabled by defining BHT_PERF_CNT_EN.
module gshare_bht_multi #(
   parameter int unsigned NR_ENTRIES      = 1024,
   parameter int unsigned INSTR_PER_FETCH = 2,
   parameter int unsigned CTR_BITS        = 2,
   parameter int unsigned HIST_BITS       = 8,
   parameter int unsigned VLEN            = 32
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               flush_i,
   input  logic               debug_mode_i,
   gshare_bht_multi_if.slave  bht,
   output logic               init_done_o
`ifdef BHT_PERF_CNT_EN
   ,
   output logic [31:0]        perf_lookup_o,
   output logic [31:0]        perf_update_o,
   output logic [31:0]        perf_mispred_o
`endif
);
   localparam int unsigned ROWS      = NR_ENTRIES / INSTR_PER_FETCH;
   localparam int unsigned ROW_BITS  = $clog2(ROWS);
   localparam int unsigned SLOT_BITS = (INSTR_PER_FETCH > 1) ? $clog2(INSTR_PER_FETCH) : 1;
   localparam int unsigned OFF       = 1 + $clog2(INSTR_PER_FETCH);
   localparam logic [CTR_BITS-1:0] CTR_WEAK = {1'b1, {(CTR_BITS-1){1'b0}}};

   typedef enum logic {CLEAR, IDLE} state_e;

   function automatic logic [CTR_BITS-1:0] sat_ctr(input logic [CTR_BITS-1:0] c,
                                                    input logic up);
      if (up) return (&c) ? c : c + CTR_BITS'(1);
      else    return (|c) ? c - CTR_BITS'(1) : c;
   endfunction

   state_e               state_q;
   logic [ROW_BITS-1:0]  clr_ptr_q;
   logic [HIST_BITS-1:0] ghr_q;
   logic                 init_done_q;

   logic                vld_q [ROWS][INSTR_PER_FETCH];
   logic [CTR_BITS-1:0] ctr_q [ROWS][INSTR_PER_FETCH];

   logic [ROW_BITS-1:0]  ghr_ext;
   logic [ROW_BITS-1:0]  pred_row;
   logic [ROW_BITS-1:0]  upd_row;
   logic [SLOT_BITS-1:0] upd_slot;
   logic                 upd_acc;
   logic                 clr;

   assign ghr_ext  = ROW_BITS'(ghr_q);
   assign pred_row = bht.vpc[OFF+ROW_BITS-1:OFF] ^ ghr_ext;
   assign upd_row  = bht.upd_pc[OFF+ROW_BITS-1:OFF] ^ ghr_ext;
   assign clr      = rst_i | flush_i;
   // A restart in the same cycle wins over any resolution update.
   assign upd_acc  = bht.upd_valid & ~debug_mode_i & init_done_q & ~clr;

   if (INSTR_PER_FETCH > 1) begin : g_slot
      assign upd_slot = bht.upd_pc[OFF-1:1];
   end else begin : g_noslot
      assign upd_slot = '0;
   end

   logic unused_bits;
   assign unused_bits = ^{bht.vpc[VLEN-1:OFF+ROW_BITS], bht.vpc[OFF-1:0],
                          bht.upd_pc[VLEN-1:OFF+ROW_BITS], bht.upd_pc[0]};

   logic [INSTR_PER_FETCH-1:0] pred_valid;
   logic [INSTR_PER_FETCH-1:0] pred_taken;

   always_comb begin
      pred_valid = '0;
      pred_taken = '0;
      for (int k = 0; k < INSTR_PER_FETCH; k++) begin
         pred_valid[k] = vld_q[pred_row][k] & init_done_q;
         pred_taken[k] = ctr_q[pred_row][k][CTR_BITS-1];
      end
   end

   assign bht.pred_valid = pred_valid;
   assign bht.pred_taken = pred_taken;
   assign init_done_o    = init_done_q;

   // Table storage: cleared only by the sweep, never by reset directly.
   always_ff @(posedge clk_i) begin
      if (state_q == CLEAR) begin
         for (int k = 0; k < INSTR_PER_FETCH; k++) begin
            vld_q[clr_ptr_q][k] <= 1'b0;
            ctr_q[clr_ptr_q][k] <= CTR_WEAK;
         end
      end else if (upd_acc) begin
         vld_q[upd_row][upd_slot] <= 1'b1;
         ctr_q[upd_row][upd_slot] <= sat_ctr(ctr_q[upd_row][upd_slot], bht.upd_taken);
      end
   end

   always_ff @(posedge clk_i) begin
      if (clr) begin
         state_q     <= CLEAR;
         clr_ptr_q   <= '0;
         ghr_q       <= '0;
         init_done_q <= 1'b0;
      end else begin
         case (state_q)
            CLEAR: begin
               clr_ptr_q <= clr_ptr_q + 1'b1;
               if (clr_ptr_q == ROW_BITS'(ROWS - 1)) begin
                  state_q     <= IDLE;
                  init_done_q <= 1'b1;
               end
            end
            IDLE: begin
               if (upd_acc) ghr_q <= HIST_BITS'({ghr_q, bht.upd_taken});
            end
            default: state_q <= CLEAR;
         endcase
      end
   end

`ifdef BHT_PERF_CNT_EN
   always_ff @(posedge clk_i) begin
      if (clr) begin
         perf_lookup_o  <= '0;
         perf_update_o  <= '0;
         perf_mispred_o <= '0;
      end else begin
         if (init_done_q) perf_lookup_o <= perf_lookup_o + 32'd1;
         if (upd_acc) begin
            perf_update_o <= perf_update_o + 32'd1;
            if (bht.upd_taken != ctr_q[upd_row][upd_slot][CTR_BITS-1])
               perf_mispred_o <= perf_mispred_o + 32'd1;
         end
      end
   end
`endif

endmodule
